serial_alu_driver: RTL and testbench
====================================

Name: serial_alu_driver

Overview:
- Bit-serial sequencer that issues WIDTH-bit operations to one external 1-bit miniALU slice cell, LSB first, and collects the slice's Output and Cout back into a WIDTH-bit result.
- Full add and subtract are built by using the half-add and half-sub slice ops twice per bit.
- Operands come in over a valid/ready request port; results go out over a valid/ready response port.
- The slice is instantiated beside this block, not inside it, so the synthesized cell can be swapped freely.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  request valid.
- op_ready  out  1  block can accept a request.
- op_code  in  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB (A−B).
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  result.
- res_flag  out  1  carry-out (ADD), borrow-out (SUB), 0 (AND/OR).
- slice_in1  out  1  to slice Input1.
- slice_in2  out  1  to slice Input2.
- slice_ctrl  out  2  to slice Control.
- slice_out  in  1  from slice Output.
- slice_cout  in  1  from slice Cout.

Behaviour:
- Slice contract (purely combinational, sampled in the same cycle it is driven):
  - 00: Output = in1 & in2, Cout = 0.
  - 01: Output = in1 | in2, Cout = 1 (ignored by this block).
  - 10: Output = in1 ^ in2, Cout = in1 & in2.
  - 11: Output = in1 ^ in2, Cout = ~in1 & in2.
- States:
  - IDLE: op_ready = 1.
  - EXEC: bit-serial execution.
  - DONE: res_valid = 1.
- Reset (async, any state): state IDLE, op_ready 1, res_valid 0, res_data 0, res_flag 0, bit counter 0, phase 0, carry 0, slice_in1/in2/ctrl 0.
- IDLE → EXEC on op_valid & op_ready:
  - Latch op_a, op_b, op_code.
  - Clear carry, counter and phase.
- In IDLE and DONE, slice_in1/in2/ctrl are driven to 0.
- EXEC, AND/OR (one cycle per bit):
  - Drive slice_ctrl = op_code, in1 = a[i], in2 = b[i].
  - Shift slice_out into the result.
- EXEC, ADD/SUB (two cycles per bit, op 10 for ADD, 11 for SUB):
  - Phase 0: drive in1 = a[i], in2 = b[i]. Capture p = slice_out and c1 = slice_cout.
  - Phase 1: drive in1 = p, in2 = carry. Shift slice_out into the result; carry ← c1 | slice_cout.
  - c1 and the phase-1 cout are never both 1.
- Result shift register shifts right with the new bit entering at the MSB, so res_data is aligned after WIDTH bits.
- After the final bit, the state is DONE:
  - res_data holds the result.
  - res_flag = final carry (ADD/SUB), 0 (AND/OR).
- Latency: res_valid rises exactly WIDTH (AND/OR) or 2·WIDTH (ADD/SUB) rising edges after the accept edge.
- DONE:
  - res_valid, res_data and res_flag are held stable until res_ready.
  - On res_valid & res_ready, go to IDLE; res_valid drops on the next edge.
  - op_ready is 0 in EXEC and DONE. A new request is never accepted in the same cycle as a result handshake.
- Arithmetic wraps modulo 2^WIDTH; overflow is visible only via res_flag.
- op_valid or operand changes during EXEC/DONE are ignored; latched values are used.
- res_ready asserted outside DONE has no effect.
- rst_n low mid-EXEC or mid-DONE aborts the operation with no result emitted. After release, the block is in IDLE.

Decomposition:
- Shared package (alu_pkg):
  - Op codes OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11.
  - State encoding IDLE/EXEC/DONE.
  - Helper function returning cycles-per-bit (1 or 2) for an op code.
- No sub-module inside the block.
- The miniALU slice is instantiated alongside it in the serial_alu top or testbench.

Test Plan (WIDTH=4, bench drives real miniALU slice):
- AND a=1100, b=1010 -> res_data=1000, flag=0, res_valid 4 edges after accept.
- OR a=1100, b=1010 -> res_data=1110, flag=0 (slice Cout=1 not propagated).
- ADD 0111+0101 -> 1100, flag 0 at 8 edges; ADD 1111+0001 -> 0000, flag 1.
- SUB 0101−0011 -> 0010, flag 0; SUB 0011−0101 -> 1110, flag 1.
- Backpressure: hold res_ready=0 for 3 cycles after res_valid -> res_data/flag stable, op_ready=0, op_valid ignored; release -> IDLE next edge, op_ready=1.
- Reset mid-op: pull rst_n low at bit 2 of an ADD -> outputs immediately at reset values, no res_valid pulse; a subsequent AND completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU driver: op codes, FSM state
// encoding and the per-op cycles-per-bit helper.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    // ADD/SUB use the half-op slice twice per bit; logic ops need one pass.
    function automatic logic [1:0] cycles_per_bit(input op_e op);
        return (op == OP_ADD || op == OP_SUB) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/serial_alu_driver.sv
// Bit-serial sequencer driving one external 1-bit miniALU slice. Operands
// are walked LSB first; full add/sub is composed from two half-op passes
// per bit, with the running carry/borrow kept here between bits.
module serial_alu_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_flag,
    output logic             slice_in1,
    output logic             slice_in2,
    output logic [1:0]       slice_ctrl,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             carry_q, carry_d;
    logic             p_q, p_d;
    logic             c1_q, c1_d;
    logic             flag_q, flag_d;

    logic             arith;
    logic             accept;
    logic             last_step;

    assign arith     = (cycles_per_bit(op_q) == 2'd2);
    assign accept    = (state_q == IDLE) && op_valid;
    // Final slice pass of the final bit: phase 1 for arithmetic, the only pass otherwise.
    assign last_step = (state_q == EXEC) && (cnt_q == LAST_BIT) && (!arith || phase_q);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept in IDLE, leave EXEC after the last pass, release DONE on handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (op_valid)  state_d = EXEC;
            EXEC:    if (last_step) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshakes from state, slice driven only while executing.
    always_comb begin
        op_ready   = (state_q == IDLE);
        res_valid  = (state_q == DONE);
        slice_in1  = 1'b0;
        slice_in2  = 1'b0;
        slice_ctrl = 2'b00;
        if (state_q == EXEC) begin
            // ADD/SUB codes coincide with the slice half-add/half-sub controls.
            slice_ctrl = op_q;
            if (arith && phase_q) begin
                slice_in1 = p_q;
                slice_in2 = carry_q;
            end else begin
                slice_in1 = a_q[cnt_q];
                slice_in2 = b_q[cnt_q];
            end
        end
    end

    assign res_data = res_q;
    assign res_flag = flag_q;

    // Datapath next-state: latch on accept, then collect one slice result per pass.
    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        carry_d = carry_q;
        p_d     = p_q;
        c1_d    = c1_q;
        flag_d  = flag_q;
        if (accept) begin
            op_d    = op_e'(op_code);
            a_d     = op_a;
            b_d     = op_b;
            cnt_d   = '0;
            phase_d = 1'b0;
            carry_d = 1'b0;
            flag_d  = 1'b0;
        end else if (state_q == EXEC) begin
            if (!arith) begin
                res_d = {slice_out, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
            end else if (!phase_q) begin
                // First half-op: partial sum/difference and its carry/borrow.
                p_d     = slice_out;
                c1_d    = slice_cout;
                phase_d = 1'b1;
            end else begin
                // Second half-op folds in the incoming carry; the two couts are exclusive.
                res_d   = {slice_out, res_q[WIDTH-1:1]};
                carry_d = c1_q | slice_cout;
                phase_d = 1'b0;
                cnt_d   = cnt_q + CW'(1);
            end
            if (last_step) begin
                cnt_d  = '0;
                flag_d = arith ? (c1_q | slice_cout) : 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            carry_q <= 1'b0;
            p_q     <= 1'b0;
            c1_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            carry_q <= carry_d;
            p_q     <= p_d;
            c1_q    <= c1_d;
            flag_q  <= flag_d;
        end
    end

endmodule

// File: tb/tb_serial_alu_driver.sv
// Testbench for serial_alu_driver with a behavioural miniALU slice wired
// alongside it; expected results come from a word-level reference model.
module tb_serial_alu_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [1:0]   op_code = 2'b00;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_flag;
    logic         slice_in1;
    logic         slice_in2;
    logic [1:0]   slice_ctrl;
    logic         slice_out;
    logic         slice_cout;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         flag;
        int           lat;
        string        name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_alu_driver #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_flag   (res_flag),
        .slice_in1  (slice_in1),
        .slice_in2  (slice_in2),
        .slice_ctrl (slice_ctrl),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
    );

    // miniALU slice cell
    always_comb begin
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (slice_ctrl)
            2'b00: begin slice_out = slice_in1 & slice_in2; slice_cout = 1'b0; end
            2'b01: begin slice_out = slice_in1 | slice_in2; slice_cout = 1'b1; end
            2'b10: begin slice_out = slice_in1 ^ slice_in2; slice_cout = slice_in1 & slice_in2; end
            default: begin slice_out = slice_in1 ^ slice_in2; slice_cout = ~slice_in1 & slice_in2; end
        endcase
    end

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input string name);
        exp_t e;
        logic [W:0] s;
        e.name = name;
        case (op)
            2'b00: begin e.data = a & b; e.flag = 1'b0; e.lat = W; end
            2'b01: begin e.data = a | b; e.flag = 1'b0; e.lat = W; end
            2'b10: begin s = {1'b0, a} + {1'b0, b}; e.data = s[W-1:0]; e.flag = s[W]; e.lat = 2 * W; end
            default: begin s = {1'b0, a} - {1'b0, b}; e.data = s[W-1:0]; e.flag = s[W]; e.lat = 2 * W; end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request and push its expectation; returns #1 after the accept edge.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        @(negedge clk);
        op_code  = op;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        check({name, "_op_ready"}, op_ready, 1);
        sb.push_back(model(op, a, b, name));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        op_code  = ~op;
    endtask

    // Wait for the result, compare against the scoreboard, optionally stall, then hand it off.
    task automatic collect(input int hold);
        exp_t         e;
        int           lat;
        logic [W-1:0] d0;
        logic         f0;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, "_latency"}, lat, e.lat);
            check({e.name, "_data"}, res_data, e.data);
            check({e.name, "_flag"}, res_flag, e.flag);
            check({e.name, "_slice_idle"}, {slice_ctrl, slice_in1, slice_in2}, 0);
        end
        d0 = res_data;
        f0 = res_flag;
        for (int i = 0; i < hold; i++) begin
            op_valid = 1'b1;
            op_code  = 2'($urandom_range(0, 3));
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            @(posedge clk);
            #1;
            check("bp_res_valid", res_valid, 1);
            check("bp_op_ready", op_ready, 0);
            check("bp_data_stable", res_data, d0);
            check("bp_flag_stable", res_flag, f0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("hs_res_valid_drop", res_valid, 0);
        check("hs_op_ready", op_ready, 1);
        op_valid = 1'b0;
    endtask

    initial begin
        // Reset values while rst_n is held low
        #12;
        check("rst_op_ready", op_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_flag", res_flag, 0);
        check("rst_slice", {slice_ctrl, slice_in1, slice_in2}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(2'b00, 4'b1100, 4'b1010, "and");  collect(0);
        send(2'b01, 4'b1100, 4'b1010, "or");   collect(0);
        send(2'b10, 4'b0111, 4'b0101, "add1"); collect(0);
        send(2'b10, 4'b1111, 4'b0001, "add2"); collect(0);
        send(2'b11, 4'b0101, 4'b0011, "sub1"); collect(0);
        send(2'b11, 4'b0011, 4'b0101, "sub2"); collect(0);
        send(2'b11, 4'b0000, 4'b0000, "sub0"); collect(0);
        send(2'b10, 4'b1001, 4'b1011, "add3"); collect(3);
        send(2'b00, 4'b1111, 4'b0110, "and2"); collect(0);

        // Reset mid-ADD at bit 2
        send(2'b10, 4'b0110, 4'b0111, "abort");
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_op_ready", op_ready, 1);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_data", res_data, 0);
        check("mid_rst_res_flag", res_flag, 0);
        check("mid_rst_slice", {slice_ctrl, slice_in1, slice_in2}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_valid", res_valid, 0);
        end
        send(2'b00, 4'b1100, 4'b1010, "and_after_rst"); collect(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
